bp_be_fp_retire: RTL and testbench
==================================

# bp_be_fp_retire

Retire stage downstream of the FP pipe (`bp_be_pipe_fp`) in the BE calculator. It captures each FP result together with its exception flags (`fflags`) and destination register. It carries them through a fixed-depth delay line up to the commit point, applying per-stage poison on the way. At commit it writes the FP register file and accumulates the flags into the sticky `fcsr.fflags` register.

## Interface
- `pipe_depth_p`, default 4: number of cycles from FP result to commit (≥1).
- `reg_data_width_p`, default 64: FP result width.
- `reg_addr_width_p`, default 5: FP register index width.

Ports:
- `clk_i`  in  1  clock; everything is sampled on the rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  an FP result is presented this cycle.
- `data_i`  in  `reg_data_width_p`  FP result; `data_o` of the FP pipe.
- `fflags_i`  in  5  exception flags {NV,DZ,OF,UF,NX}; `fflags_o` of the FP pipe.
- `rd_addr_i`  in  `reg_addr_width_p`  destination register.
- `frf_w_v_i`  in  1  the op writes the FP register file (0 for compares/moves to the integer side).
- `stall_i`  in  1  freezes the delay line.
- `poison_i`  in  `pipe_depth_p`  bit k kills the entry in stage k.
- `fflags_w_v_i`  in  1  CSR write to fflags.
- `fflags_w_data_i`  in  5  CSR write data.
- `wb_v_o`  out  1  FP register file write enable.
- `wb_rd_addr_o`  out  `reg_addr_width_p`  write address.
- `wb_data_o`  out  `reg_data_width_p`  write data.
- `commit_v_o`  out  1  an FP op commits this cycle, whether or not it writes the FP register file.
- `fflags_o`  out  5  sticky accumulated flags.

## Operation
- Stages s[0..D-1] (D = `pipe_depth_p`). Each stage holds {v, frf_w_v, rd_addr, data, fflags}.
- On a non-stall edge:
  - s[0] ← input entry with v = `valid_i` & ~`poison_i`[0]-of-next-cycle-not-applied.
  - More precisely, the incoming entry is only affected by poison once it has entered s[0].
  - s[k] ← s[k-1] for k ≥ 1. The v bit of each source stage is masked by the current `poison_i` bit of that stage.
- Poison on a stall edge: stages hold; any stage k with `poison_i`[k]=1 clears its v bit.
- Poison always acts in the same cycle. A poisoned s[D-1] does not commit that cycle.
- Commit condition: `commit_v_o` = s[D-1].v & ~`poison_i`[D-1] & ~`stall_i`.
- Writeback: `wb_v_o` = `commit_v_o` & s[D-1].frf_w_v. `wb_rd_addr_o` and `wb_data_o` are driven from s[D-1] unconditionally; they are don't-care when `wb_v_o`=0.
- Flag update, priority order:
  1. If `fflags_w_v_i`: `fflags_o` ← `fflags_w_data_i`. The CSR write wins and committing flags that cycle are discarded.
  2. Else if `commit_v_o`: `fflags_o` ← `fflags_o` | s[D-1].fflags.
  3. Else: hold.
- `valid_i` during `stall_i` is ignored. Upstream must hold the op until the stall releases.
- Flags and data of invalid stages are never consumed.

## Timing
- Reset (synchronous): all v bits cleared and `fflags_o` = 0 on the next edge. `wb_v_o` and `commit_v_o` read 0 from the cycle after reset is sampled.
- Reset mid-operation: in-flight entries are discarded and never commit.
- Latency: `valid_i` accepted in cycle T (no stall) gives `commit_v_o`/`wb_v_o` in cycle T+D, provided there are no stalls and no poison. Each stall cycle adds one.
- `fflags_o` reflects a commit in cycle T+D+1.
- Outputs `wb_*` and `commit_v_o` are combinational from state plus `stall_i`/`poison_i`. There is no combinational path from `valid_i`/`data_i` to any output.
- Throughput: one op per non-stall cycle. Back-to-back ops commit on consecutive cycles.

## Test plan
- Reset, then `valid_i`=1, `data_i`=64'h3FF0_0000_0000_0000, rd=5, `fflags_i`=5'b00001, `frf_w_v_i`=1 in cycle 0 (D=4). Expect `wb_v_o`=1, rd=5, data matches in cycle 4, and `fflags_o`=5'b00001 in cycle 5.
- Four back-to-back ops with flags NX, UF, OF, DZ. Expect four consecutive commits and final `fflags_o`=5'b01111.
- Op in flight at s[2] with `poison_i`=4'b0100 for one cycle. Expect no commit and `fflags_o` unchanged. Neighbouring ops still commit.
- `stall_i` held for 3 cycles while an op sits in s[3]. Expect `commit_v_o`=0 throughout; commit occurs in the first cycle after the stall releases. Then `poison_i`[3] during a stall: entry dropped.
- `fflags_o`=5'b10000 with `fflags_w_v_i`=1, data 5'b00010, in the same cycle as a commit with NX. Expect `fflags_o`=5'b00010.
- Op with `frf_w_v_i`=0 and NV. Expect `commit_v_o`=1, `wb_v_o`=0, and the NV flag accumulated. `reset_i` asserted with 3 ops in flight: no commits, `fflags_o`=0.

Source files
------------

// File: rtl/bp_be_fp_retire.sv
// FP retire stage: carries FP results, flags and destination through a fixed-depth
// delay line with per-stage poison, then writes the FP register file and sticky fflags.
module bp_be_fp_retire #(
    parameter int unsigned pipe_depth_p     = 4,
    parameter int unsigned reg_data_width_p = 64,
    parameter int unsigned reg_addr_width_p = 5
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        valid_i,
    input  logic [reg_data_width_p-1:0] data_i,
    input  logic [4:0]                  fflags_i,
    input  logic [reg_addr_width_p-1:0] rd_addr_i,
    input  logic                        frf_w_v_i,
    input  logic                        stall_i,
    input  logic [pipe_depth_p-1:0]     poison_i,
    input  logic                        fflags_w_v_i,
    input  logic [4:0]                  fflags_w_data_i,
    output logic                        wb_v_o,
    output logic [reg_addr_width_p-1:0] wb_rd_addr_o,
    output logic [reg_data_width_p-1:0] wb_data_o,
    output logic                        commit_v_o,
    output logic [4:0]                  fflags_o
);

    localparam int unsigned last_lp = pipe_depth_p - 1;

    logic                        v_r      [pipe_depth_p];
    logic                        frf_w_r  [pipe_depth_p];
    logic [reg_addr_width_p-1:0] rd_r     [pipe_depth_p];
    logic [reg_data_width_p-1:0] data_r   [pipe_depth_p];
    logic [4:0]                  flags_r  [pipe_depth_p];
    logic [4:0]                  fflags_r;

    // Stage 0: a newly accepted op is not subject to poison until it has entered s[0].
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_r[0] <= 1'b0;
        end else if (stall_i) begin
            v_r[0] <= v_r[0] & ~poison_i[0];
        end else begin
            v_r[0] <= valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!stall_i) begin
            frf_w_r[0] <= frf_w_v_i;
            rd_r[0]    <= rd_addr_i;
            data_r[0]  <= data_i;
            flags_r[0] <= fflags_i;
        end
    end

    for (genvar k = 1; k < pipe_depth_p; k++) begin : g_stage
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                v_r[k] <= 1'b0;
            end else if (stall_i) begin
                v_r[k] <= v_r[k] & ~poison_i[k];
            end else begin
                v_r[k] <= v_r[k-1] & ~poison_i[k-1];
            end
        end

        always_ff @(posedge clk_i) begin
            if (!stall_i) begin
                frf_w_r[k] <= frf_w_r[k-1];
                rd_r[k]    <= rd_r[k-1];
                data_r[k]  <= data_r[k-1];
                flags_r[k] <= flags_r[k-1];
            end
        end
    end

    always_comb begin
        commit_v_o   = v_r[last_lp] & ~poison_i[last_lp] & ~stall_i;
        wb_v_o       = commit_v_o & frf_w_r[last_lp];
        wb_rd_addr_o = rd_r[last_lp];
        wb_data_o    = data_r[last_lp];
    end

    // A CSR write overrides, and discards, flags committing in the same cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fflags_r <= '0;
        end else if (fflags_w_v_i) begin
            fflags_r <= fflags_w_data_i;
        end else if (commit_v_o) begin
            fflags_r <= fflags_r | flags_r[last_lp];
        end
    end

    assign fflags_o = fflags_r;

endmodule

// File: tb/tb_bp_be_fp_retire.sv
// Self-checking bench for bp_be_fp_retire: directed vector table, hand-written corner
// sequences and randomized traffic checked against an op-list reference model.
module tb_bp_be_fp_retire;

    localparam int D = 4;

    logic        clk;
    logic        reset_i;
    logic        valid_i;
    logic [63:0] data_i;
    logic [4:0]  fflags_i;
    logic [4:0]  rd_addr_i;
    logic        frf_w_v_i;
    logic        stall_i;
    logic [D-1:0] poison_i;
    logic        fflags_w_v_i;
    logic [4:0]  fflags_w_data_i;
    logic        wb_v_o;
    logic [4:0]  wb_rd_addr_o;
    logic [63:0] wb_data_o;
    logic        commit_v_o;
    logic [4:0]  fflags_o;

    bp_be_fp_retire #(
        .pipe_depth_p    (D),
        .reg_data_width_p(64),
        .reg_addr_width_p(5)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .valid_i        (valid_i),
        .data_i         (data_i),
        .fflags_i       (fflags_i),
        .rd_addr_i      (rd_addr_i),
        .frf_w_v_i      (frf_w_v_i),
        .stall_i        (stall_i),
        .poison_i       (poison_i),
        .fflags_w_v_i   (fflags_w_v_i),
        .fflags_w_data_i(fflags_w_data_i),
        .wb_v_o         (wb_v_o),
        .wb_rd_addr_o   (wb_rd_addr_o),
        .wb_data_o      (wb_data_o),
        .commit_v_o     (commit_v_o),
        .fflags_o       (fflags_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         rst;
        logic         valid;
        logic [63:0]  data;
        logic [4:0]   fl;
        logic [4:0]   rd;
        logic         frf;
        logic         stall;
        logic [D-1:0] poison;
        logic         fw_v;
        logic [4:0]   fw_d;
        logic         tchk;
        logic         e_commit;
        logic         e_wb;
        logic [4:0]   e_rd;
        logic [63:0]  e_data;
        logic [4:0]   e_flags;
    } vec_t;

    // Reference model: list of live ops, each knowing which stage it occupies.
    typedef struct {
        int          pos;
        logic        frf;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [4:0]  fl;
    } op_t;

    op_t        q[$];
    logic [4:0] m_flags;
    int         checks;
    int         errors;
    int         ncommit;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t idle();
        vec_t v;
        v = '0;
        return v;
    endfunction

    function automatic vec_t op(input logic [63:0] d, input logic [4:0] fl,
                                input logic [4:0] rd, input logic frf);
        vec_t v;
        v = '0;
        v.valid = 1'b1;
        v.data  = d;
        v.fl    = fl;
        v.rd    = rd;
        v.frf   = frf;
        return v;
    endfunction

    function automatic vec_t expect_out(input vec_t v, input logic c, input logic wb,
                                        input logic [4:0] rd, input logic [63:0] d,
                                        input logic [4:0] fl);
        vec_t r;
        r = v;
        r.tchk     = 1'b1;
        r.e_commit = c;
        r.e_wb     = wb;
        r.e_rd     = rd;
        r.e_data   = d;
        r.e_flags  = fl;
        return r;
    endfunction

    // Apply one cycle of stimulus, compare against model (and table if requested), advance.
    task automatic run(input vec_t v);
        logic exp_c;
        op_t  ce;
        op_t  nq[$];
        op_t  n;
        reset_i         = v.rst;
        valid_i         = v.valid;
        data_i          = v.data;
        fflags_i        = v.fl;
        rd_addr_i       = v.rd;
        frf_w_v_i       = v.frf;
        stall_i         = v.stall;
        poison_i        = v.poison;
        fflags_w_v_i    = v.fw_v;
        fflags_w_data_i = v.fw_d;
        #4;
        exp_c = 1'b0;
        ce    = '{pos: 0, frf: 1'b0, rd: '0, data: '0, fl: '0};
        foreach (q[i]) begin
            if (q[i].pos == D - 1 && !v.poison[D-1] && !v.stall) begin
                exp_c = 1'b1;
                ce    = q[i];
            end
        end
        chk("model_commit", {63'd0, commit_v_o}, {63'd0, exp_c});
        chk("model_wb_v", {63'd0, wb_v_o}, {63'd0, exp_c & ce.frf});
        if (exp_c && ce.frf) begin
            chk("model_wb_rd", {59'd0, wb_rd_addr_o}, {59'd0, ce.rd});
            chk("model_wb_data", wb_data_o, ce.data);
        end
        chk("model_fflags", {59'd0, fflags_o}, {59'd0, m_flags});
        if (v.tchk) begin
            chk("vec_commit", {63'd0, commit_v_o}, {63'd0, v.e_commit});
            chk("vec_wb_v", {63'd0, wb_v_o}, {63'd0, v.e_wb});
            chk("vec_fflags", {59'd0, fflags_o}, {59'd0, v.e_flags});
            if (v.e_wb) begin
                chk("vec_wb_rd", {59'd0, wb_rd_addr_o}, {59'd0, v.e_rd});
                chk("vec_wb_data", wb_data_o, v.e_data);
            end
        end
        if (commit_v_o === 1'b1) ncommit++;
        @(posedge clk);
        if (v.rst) begin
            q.delete();
            m_flags = '0;
        end else begin
            if (v.fw_v) m_flags = v.fw_d;
            else if (exp_c) m_flags = m_flags | ce.fl;
            foreach (q[i]) begin
                n = q[i];
                if (v.poison[n.pos]) continue;
                if (!v.stall) begin
                    if (n.pos == D - 1) continue;
                    n.pos++;
                end
                nq.push_back(n);
            end
            if (!v.stall && v.valid) begin
                nq.push_back('{pos: 0, frf: v.frf, rd: v.rd, data: v.data, fl: v.fl});
            end
            q = nq;
        end
        #1;
    endtask

    vec_t tbl[15];
    vec_t v;
    int   c0;

    initial begin
        checks  = 0;
        errors  = 0;
        ncommit = 0;
        m_flags = '0;

        reset_i = 1'b1; valid_i = 1'b0; data_i = '0; fflags_i = '0; rd_addr_i = '0;
        frf_w_v_i = 1'b0; stall_i = 1'b0; poison_i = '0; fflags_w_v_i = 1'b0;
        fflags_w_data_i = '0;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Single op (latency D, flags one cycle later), then four back-to-back ops.
        for (int i = 0; i < 15; i++) tbl[i] = expect_out(idle(), 1'b0, 1'b0, '0, '0, 5'b00000);
        tbl[0]  = expect_out(op(64'h3FF0_0000_0000_0000, 5'b00001, 5'd5, 1'b1), 1'b0, 1'b0, '0, '0, 5'b00000);
        tbl[4]  = expect_out(idle(), 1'b1, 1'b1, 5'd5, 64'h3FF0_0000_0000_0000, 5'b00000);
        tbl[5]  = expect_out(op(64'h4000_0000_0000_0001, 5'b00001, 5'd1, 1'b1), 1'b0, 1'b0, '0, '0, 5'b00001);
        tbl[6]  = expect_out(op(64'h4000_0000_0000_0002, 5'b00010, 5'd2, 1'b1), 1'b0, 1'b0, '0, '0, 5'b00001);
        tbl[7]  = expect_out(op(64'h4000_0000_0000_0003, 5'b00100, 5'd3, 1'b1), 1'b0, 1'b0, '0, '0, 5'b00001);
        tbl[8]  = expect_out(op(64'h4000_0000_0000_0004, 5'b01000, 5'd4, 1'b1), 1'b0, 1'b0, '0, '0, 5'b00001);
        tbl[9]  = expect_out(idle(), 1'b1, 1'b1, 5'd1, 64'h4000_0000_0000_0001, 5'b00001);
        tbl[10] = expect_out(idle(), 1'b1, 1'b1, 5'd2, 64'h4000_0000_0000_0002, 5'b00001);
        tbl[11] = expect_out(idle(), 1'b1, 1'b1, 5'd3, 64'h4000_0000_0000_0003, 5'b00011);
        tbl[12] = expect_out(idle(), 1'b1, 1'b1, 5'd4, 64'h4000_0000_0000_0004, 5'b00111);
        tbl[13] = expect_out(idle(), 1'b0, 1'b0, '0, '0, 5'b01111);
        tbl[14] = expect_out(idle(), 1'b0, 1'b0, '0, '0, 5'b01111);
        for (int i = 0; i < 15; i++) run(tbl[i]);

        // Poison the middle of three back-to-back ops while it sits in s[2].
        v = idle(); v.fw_v = 1'b1; v.fw_d = 5'b00000; run(v);
        c0 = ncommit;
        run(op(64'hA1, 5'b00001, 5'd10, 1'b1));
        run(op(64'hA2, 5'b00100, 5'd11, 1'b1));
        run(op(64'hA3, 5'b00010, 5'd12, 1'b1));
        run(idle());
        v = idle(); v.poison = 4'b0100; run(v);
        for (int i = 0; i < 5; i++) run(idle());
        chk("poison_commits", 64'(ncommit - c0), 64'd2);
        chk("poison_fflags", {59'd0, fflags_o}, {59'd0, 5'b00011});

        // Stall for three cycles with the op in s[3], then poison s[3] during a stall.
        v = idle(); v.fw_v = 1'b1; run(v);
        run(op(64'hB7, 5'b00001, 5'd7, 1'b1));
        for (int i = 0; i < 3; i++) run(idle());
        for (int i = 0; i < 3; i++) begin
            v = idle(); v.stall = 1'b1;
            run(expect_out(v, 1'b0, 1'b0, '0, '0, 5'b00000));
        end
        run(expect_out(idle(), 1'b1, 1'b1, 5'd7, 64'hB7, 5'b00000));
        run(expect_out(op(64'hB8, 5'b00100, 5'd8, 1'b1), 1'b0, 1'b0, '0, '0, 5'b00001));
        for (int i = 0; i < 3; i++) run(idle());
        v = idle(); v.stall = 1'b1; v.poison = 4'b1000;
        run(expect_out(v, 1'b0, 1'b0, '0, '0, 5'b00001));
        for (int i = 0; i < 2; i++) run(expect_out(idle(), 1'b0, 1'b0, '0, '0, 5'b00001));

        // CSR write in the same cycle as a commit wins.
        v = idle(); v.fw_v = 1'b1; v.fw_d = 5'b10000; run(v);
        run(op(64'hC1, 5'b00001, 5'd3, 1'b1));
        for (int i = 0; i < 3; i++) run(idle());
        v = idle(); v.fw_v = 1'b1; v.fw_d = 5'b00010;
        run(expect_out(v, 1'b1, 1'b1, 5'd3, 64'hC1, 5'b10000));
        run(expect_out(idle(), 1'b0, 1'b0, '0, '0, 5'b00010));

        // Commit without FP register write still accumulates NV.
        v = idle(); v.fw_v = 1'b1; run(v);
        run(op(64'hD1, 5'b10000, 5'd9, 1'b0));
        for (int i = 0; i < 3; i++) run(idle());
        run(expect_out(idle(), 1'b1, 1'b0, '0, '0, 5'b00000));
        run(expect_out(idle(), 1'b0, 1'b0, '0, '0, 5'b10000));

        // Reset with three ops in flight discards them all.
        run(op(64'hE1, 5'b00001, 5'd1, 1'b1));
        run(op(64'hE2, 5'b00010, 5'd2, 1'b1));
        run(op(64'hE3, 5'b00100, 5'd3, 1'b1));
        v = idle(); v.rst = 1'b1; run(v);
        for (int i = 0; i < 6; i++) run(expect_out(idle(), 1'b0, 1'b0, '0, '0, 5'b00000));

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            v        = idle();
            v.valid  = 1'($urandom_range(0, 1));
            v.data   = {$urandom, $urandom};
            v.fl     = 5'($urandom);
            v.rd     = 5'($urandom);
            v.frf    = ($urandom_range(0, 3) != 0);
            v.stall  = ($urandom_range(0, 3) == 0);
            v.poison = ($urandom_range(0, 4) == 0) ? D'($urandom) : '0;
            v.fw_v   = ($urandom_range(0, 15) == 0);
            v.fw_d   = 5'($urandom);
            v.rst    = ($urandom_range(0, 63) == 0);
            run(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
